// File: rtl/keyboard_matrix.sv
// Emulated PET keyboard matrix: MCU loads key state over Wishbone,
// and CPU writes to PIA1 are snooped to pick the column whose row byte is returned.
module keyboard_matrix #(
    parameter int COL_COUNT  = 10,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [7:0]            wb_dat_i,
    output logic [7:0]            wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    input  logic                  pia1_strobe_i,
    input  logic [1:0]            pia1_rs_i,
    input  logic                  pia1_we_i,
    input  logic [7:0]            pia1_dat_i,
    output logic [3:0]            kbd_col_o,
    output logic [7:0]            kbd_row_o
);

    localparam int IW = $clog2(COL_COUNT);

    localparam logic [ADDR_WIDTH-1:0] REG_IO_PIA1_PORTA = ADDR_WIDTH'(16);
    localparam logic [ADDR_WIDTH-1:0] REG_IO_PIA1_CRA   = ADDR_WIDTH'(17);
    localparam logic [ADDR_WIDTH-1:0] MATRIX_END        = ADDR_WIDTH'(COL_COUNT);

    localparam logic [1:0] PIA_PORTA = 2'd0;
    localparam logic [1:0] PIA_CRA   = 2'd1;

    logic [7:0]    matrix [COL_COUNT];
    logic [3:0]    col;
    logic          cra2;
    logic [7:0]    ddra;
    logic          access;
    logic          in_matrix;
    logic          col_valid;
    logic [IW-1:0] wb_idx;
    logic [IW-1:0] col_idx;
    logic [7:0]    rd_data;

    // DDRA is tracked for completeness but nothing downstream consumes it.
    logic unused_ddra;
    assign unused_ddra = ^ddra;

    assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign in_matrix = wb_adr_i < MATRIX_END;
    assign col_valid = col < 4'(COL_COUNT);
    assign wb_idx    = wb_adr_i[IW-1:0];
    assign col_idx   = col[IW-1:0];
    assign kbd_col_o = col;

    always_comb begin
        rd_data = 8'h00;
        unique case (1'b1)
            in_matrix:                       rd_data = matrix[wb_idx];
            (wb_adr_i == REG_IO_PIA1_PORTA): rd_data = {4'hF, col};
            (wb_adr_i == REG_IO_PIA1_CRA):   rd_data = {5'b0, cra2, 2'b0};
            default:                         rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < COL_COUNT; i++) begin
                matrix[i] <= 8'hFF;
            end
            col       <= 4'hF;
            cra2      <= 1'b0;
            ddra      <= 8'h00;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 8'h00;
            kbd_row_o <= 8'hFF;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= access ? rd_data : 8'h00;

            if (access && wb_we_i && in_matrix) begin
                matrix[wb_idx] <= wb_dat_i;
            end

            if (pia1_strobe_i && pia1_we_i) begin
                case (pia1_rs_i)
                    PIA_CRA: cra2 <= pia1_dat_i[2];
                    PIA_PORTA: begin
                        // CRA bit 2 selects between the data port and DDRA
                        if (cra2) begin
                            col <= pia1_dat_i[3:0];
                        end else begin
                            ddra <= pia1_dat_i;
                        end
                    end
                    default: ;
                endcase
            end

            kbd_row_o <= col_valid ? matrix[col_idx] : 8'hFF;
        end
    end

endmodule

// File: tb/tb_keyboard_matrix.sv
// Directed and randomized checks of keyboard_matrix against
// a simple array model of the key matrix and PIA1 snoop state.
module tb_keyboard_matrix;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [4:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we_i;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_ack_o;
    logic       pia1_strobe_i;
    logic [1:0] pia1_rs_i;
    logic       pia1_we_i;
    logic [7:0] pia1_dat_i;
    logic [3:0] kbd_col_o;
    logic [7:0] kbd_row_o;

    keyboard_matrix #(.COL_COUNT(10), .ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o),
        .pia1_strobe_i(pia1_strobe_i), .pia1_rs_i(pia1_rs_i),
        .pia1_we_i(pia1_we_i), .pia1_dat_i(pia1_dat_i),
        .kbd_col_o(kbd_col_o), .kbd_row_o(kbd_row_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_key [10];
    int m_col;
    int m_cra2;

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_key[i] = 8'hFF;
        m_col  = 15;
        m_cra2 = 0;
    endtask

    function automatic logic [7:0] model_row();
        return (m_col < 10) ? 8'(m_key[m_col]) : 8'hFF;
    endfunction

    function automatic logic [7:0] model_rd(int adr);
        if (adr < 10) return 8'(m_key[adr]);
        if (adr == 16) return {4'hF, 4'(m_col)};
        if (adr == 17) return 8'(m_cra2 * 4);
        return 8'h00;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(int adr, bit we, logic [7:0] dat, output logic [7:0] rdata);
        @(negedge clk_i);
        wb_adr_i = 5'(adr);
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ack_high", {7'b0, wb_ack_o}, 8'h01);
        rdata = wb_dat_o;
        if (we && adr < 10) m_key[adr] = dat;
        @(negedge clk_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk_i); #1;
        chk("ack_one_cycle", {7'b0, wb_ack_o}, 8'h00);
    endtask

    task automatic wb_read_chk(int adr, string tag);
        logic [7:0] r;
        wb_cycle(adr, 1'b0, 8'h00, r);
        chk(tag, r, model_rd(adr));
    endtask

    task automatic wb_write(int adr, logic [7:0] dat);
        logic [7:0] r;
        wb_cycle(adr, 1'b1, dat, r);
    endtask

    task automatic pia_access(logic [1:0] rs, bit we, logic [7:0] dat);
        @(negedge clk_i);
        pia1_rs_i     = rs;
        pia1_we_i     = we;
        pia1_dat_i    = dat;
        pia1_strobe_i = 1'b1;
        @(negedge clk_i);
        pia1_strobe_i = 1'b0;
        pia1_we_i     = 1'b0;
        if (we && rs == 2'd1) m_cra2 = int'(dat[2]);
        if (we && rs == 2'd0 && m_cra2 == 1) m_col = int'(dat[3:0]);
    endtask

    task automatic check_out(string tag);
        @(posedge clk_i); #1;
        chk({tag, "_col"}, {4'h0, kbd_col_o}, {4'h0, 4'(m_col)});
        chk({tag, "_row"}, kbd_row_o, model_row());
    endtask

    initial begin
        logic [7:0] r;
        int acks;
        rst_n_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        pia1_strobe_i = 1'b0; pia1_rs_i = '0; pia1_we_i = 1'b0; pia1_dat_i = '0;
        model_reset();

        // 1. reset state
        #12;
        chk("rst_row", kbd_row_o, 8'hFF);
        chk("rst_col", {4'h0, kbd_col_o}, 8'h0F);
        chk("rst_ack", {7'b0, wb_ack_o}, 8'h00);
        chk("rst_dat", wb_dat_o, 8'h00);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) wb_read_chk(i, "rst_matrix");

        // 2. key down at column 3
        wb_write(3, 8'hFE);
        pia_access(2'd1, 1'b1, 8'h04);
        pia_access(2'd0, 1'b1, 8'h03);
        chk("col3_now", {4'h0, kbd_col_o}, 8'h03);
        check_out("col3");
        chk("col3_row_fe", kbd_row_o, 8'hFE);

        // 3. DDRA write leaves column alone; column 12 reads no keys
        pia_access(2'd1, 1'b1, 8'h00);
        pia_access(2'd0, 1'b1, 8'h05);
        check_out("ddra");
        wb_read_chk(17, "cra_rd_0");
        pia_access(2'd1, 1'b1, 8'h04);
        pia_access(2'd0, 1'b1, 8'h0C);
        check_out("col12");
        chk("col12_row_ff", kbd_row_o, 8'hFF);
        wb_read_chk(17, "cra_rd_4");
        pia_access(2'd0, 1'b1, 8'h03);
        check_out("back3");

        // 4. same-edge matrix write and column change
        @(negedge clk_i);
        wb_adr_i = 5'd7; wb_dat_i = 8'h7F; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        pia1_rs_i = 2'd0; pia1_we_i = 1'b1; pia1_dat_i = 8'h07; pia1_strobe_i = 1'b1;
        @(posedge clk_i); #1;
        chk("same_edge_ack", {7'b0, wb_ack_o}, 8'h01);
        m_key[7] = 8'h7F;
        m_col = 7;
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        pia1_strobe_i = 1'b0; pia1_we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("same_edge_row", kbd_row_o, 8'h7F);
        chk("same_edge_col", {4'h0, kbd_col_o}, 8'h07);

        // 5. out-of-range writes are discarded
        wb_write(10, 8'h00);
        wb_write(31, 8'h00);
        for (int i = 0; i < 10; i++) wb_read_chk(i, "no_alias");
        wb_read_chk(16, "porta_rd");
        wb_read_chk(20, "other_rd");

        // held strobe acks every other cycle
        @(negedge clk_i);
        wb_adr_i = 5'd7; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) acks++;
        end
        chk("held_stb_acks", 8'(acks), 8'd2);
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); #1;

        // abandoned cycle
        @(negedge clk_i);
        wb_adr_i = 5'd1; wb_dat_i = 8'h00; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #2;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abandon_ack", {7'b0, wb_ack_o}, 8'h00);
        wb_read_chk(1, "abandon_mtx");

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: wb_write(int'($urandom_range(0, 31)), 8'($urandom));
                1: wb_read_chk(int'($urandom_range(0, 31)), "rnd_rd");
                2: pia_access(2'($urandom_range(0, 3)), 1'b1,
                              8'($urandom_range(0, 1) * 4 + $urandom_range(0, 255) * 0));
                default: pia_access(2'd0, 1'($urandom_range(0, 1)),
                                    8'($urandom_range(0, 15)));
            endcase
            check_out("rnd");
        end

        // 6. reset during write ack
        @(negedge clk_i);
        wb_adr_i = 5'd2; wb_dat_i = 8'h55; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk_i); #1;
        chk("pre_rst_ack", {7'b0, wb_ack_o}, 8'h01);
        rst_n_i = 1'b0;
        #1;
        chk("async_ack_drop", {7'b0, wb_ack_o}, 8'h00);
        chk("async_row", kbd_row_o, 8'hFF);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        wb_read_chk(2, "rst_mtx2");
        check_out("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
